imem_arbiter: RTL

Single-cycle arbiter and sequencer for the processor's single-port, synchronous instruction memory (20-bit words, 15-bit word address, DEPTH entries). Shares the memory between the pipeline fetch stage (PCF) and the program loader/debug port. After reset it optionally zero-fills the whole memory before granting anyone. It sits between the fetch stage, the loader and the memory macro, and drives the memory's address, write-enable and write-data pins.

---
 rtl/imem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch/loader arbiter and sequencer for a single-port synchronous instruction memory.
// Optional post-reset zero-fill sweep is compiled in when IMEM_CLEAR_EN is defined.
module imem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 20,
  parameter int DEPTH        = 512,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LIMIT   = 4'(STARVE_LIMIT);

  logic              run;
  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;

`ifdef IMEM_CLEAR_EN
  localparam int               CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run      = (state_q == S_RUN);
  // Gating with the reset pin keeps mem_we low while reset is still held.
  assign clearing = (state_q == S_CLEAR) && reset;
  assign clr_addr = ADDR_W'(cnt_q);
`else
  assign run      = reset;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  logic              fetch_oor, load_oor;
  logic [3:0]        starve_q, starve_d;
  owner_e            owner_q, owner_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] fetch_hold_q, fetch_hold_d;
  logic [DATA_W-1:0] load_hold_q, load_hold_d;
  logic [DATA_W-1:0] rdata_sel;

  assign fetch_oor   = ({1'b0, fetch_addr} >= DEPTH_X);
  assign load_oor    = ({1'b0, load_addr} >= DEPTH_X);
  assign ready       = run;
  assign fetch_stall = fetch_req & ~fetch_gnt & reset;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (run) begin
      if (load_req && (!fetch_req || starve_q == LIMIT)) load_gnt  = 1'b1;
      else if (fetch_req)                                fetch_gnt = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!load_req || load_gnt)              starve_d = '0;
    else if (fetch_gnt && starve_q != LIMIT) starve_d = starve_q + 1'b1;

    owner_d = OWN_NONE;
    oor_d   = 1'b0;
    if (fetch_gnt) begin
      owner_d = OWN_FETCH;
      oor_d   = fetch_oor;
    end else if (load_gnt && !load_we) begin
      owner_d = OWN_LOAD;
      oor_d   = load_oor;
    end

    // Idle cycles park the address on its last value.
    mem_addr  = last_addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (clearing) begin
      mem_addr = clr_addr;
      mem_we   = 1'b1;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else if (load_gnt) begin
      mem_addr = load_addr;
      mem_we   = load_we & ~load_oor;
      if (load_we) mem_wdata = load_wdata;
    end
    last_addr_d = mem_addr;
  end

  always_comb begin
    rdata_sel    = oor_q ? '0 : mem_rdata;
    fetch_valid  = (owner_q == OWN_FETCH);
    load_valid   = (owner_q == OWN_LOAD);
    fetch_data   = fetch_valid ? rdata_sel : fetch_hold_q;
    load_rdata   = load_valid ? rdata_sel : load_hold_q;
    fetch_hold_d = fetch_data;
    load_hold_d  = load_rdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q     <= '0;
      owner_q      <= OWN_NONE;
      oor_q        <= 1'b0;
      last_addr_q  <= '0;
      fetch_hold_q <= '0;
      load_hold_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      owner_q      <= owner_d;
      oor_q        <= oor_d;
      last_addr_q  <= last_addr_d;
      fetch_hold_q <= fetch_hold_d;
      load_hold_q  <= load_hold_d;
    end
  end

endmodule
